// File: rtl/alarm_ctrl_pkg.sv
// Shared constants for the alarm clock controller: state encoding, field limits
// and the wrap-around increment used by every editable field.
package alarm_ctrl_pkg;

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_SET_HR = 3'd1;
  localparam logic [2:0] ST_SET_MIN = 3'd2;
  localparam logic [2:0] ST_AL_HR  = 3'd3;
  localparam logic [2:0] ST_AL_MIN = 3'd4;
  localparam logic [2:0] ST_RING   = 3'd5;
  localparam logic [2:0] ST_SNOOZE = 3'd6;

  localparam logic [7:0] MAX_HR  = 8'd23;
  localparam logic [7:0] MAX_MIN = 8'd59;

  // Out-of-range values also fold back to zero so a bad copy never sticks.
  function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max);
    return (value >= max) ? 8'd0 : value + 8'd1;
  endfunction

endpackage

// File: rtl/alarm_clock_ctrl_sec_timer.sv
// Seconds timer shared by the ring timeout (counting up) and the snooze
// countdown (counting down); terminal flags the tick that should end the phase.
module ctrl_sec_timer
  import alarm_ctrl_pkg::*;
#(
  parameter int TMR_W    = 12,
  parameter int UP_LIMIT = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clear,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             down,
  output logic [TMR_W-1:0] value,
  output logic             zero,
  output logic             terminal
);

  localparam logic [TMR_W-1:0] UP_LAST = TMR_W'(UP_LIMIT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (tick) begin
      value <= down ? value - 1'b1 : value + 1'b1;
    end
  end

  assign zero = (value == '0);
  // Up: the next tick reaches UP_LIMIT. Down: the next tick reaches zero.
  assign terminal = down ? (value == TMR_W'(1)) : (value >= UP_LAST);

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Mode/scheduling controller for the alarm clock: gates the time counter,
// runs time-set and alarm-set editing, and drives ring, ring timeout and snooze.
module alarm_clock_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int TMR_W      = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_alarm,
  input  logic       btn_inc,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  input  logic [7:0] cur_hr,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       cnt_enable,
  output logic       load,
  output logic [7:0] load_hr,
  output logic [7:0] load_min,
  output logic [7:0] alarm_hr,
  output logic [7:0] alarm_min,
  output logic       alarm_armed,
  output logic       ring,
  output logic [2:0] state_o
);

  localparam logic [TMR_W-1:0] SNOOZE_TICKS = TMR_W'(SNOOZE_MIN * 60);

  logic [2:0]       state, state_n;
  logic [7:0]       load_hr_n, load_min_n, alarm_hr_n, alarm_min_n;
  logic             armed_n, load_n;
  logic             match, match_q;
  logic             p_stop, p_snooze, p_mode, p_alarm, p_inc;
  logic             tmr_clear, tmr_load, tmr_tick, tmr_down;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_zero, tmr_terminal;
  logic             unused;

  // Single winner per cycle: stop > snooze > mode > alarm > inc.
  assign p_stop   = btn_stop;
  assign p_snooze = btn_snooze & ~btn_stop;
  assign p_mode   = btn_mode & ~btn_stop & ~btn_snooze;
  assign p_alarm  = btn_alarm & ~btn_stop & ~btn_snooze & ~btn_mode;
  assign p_inc    = btn_inc & ~btn_stop & ~btn_snooze & ~btn_mode & ~btn_alarm;

  assign match    = alarm_armed && (cur_hr == alarm_hr) && (cur_min == alarm_min);
  assign tmr_down = (state == ST_SNOOZE);

  ctrl_sec_timer #(
    .TMR_W    (TMR_W),
    .UP_LIMIT (RING_SEC)
  ) u_sec_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tmr_tick),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (SNOOZE_TICKS),
    .down     (tmr_down),
    .value    (tmr_value),
    .zero     (tmr_zero),
    .terminal (tmr_terminal)
  );

  // Seconds come straight from the counter; only hour/minute matter here.
  assign unused = ^{cur_sec, tmr_value, tmr_zero};

  always_comb begin
    state_n     = state;
    load_hr_n   = load_hr;
    load_min_n  = load_min;
    alarm_hr_n  = alarm_hr;
    alarm_min_n = alarm_min;
    armed_n     = alarm_armed;
    load_n      = 1'b0;
    tmr_clear   = 1'b0;
    tmr_load    = 1'b0;
    tmr_tick    = 1'b0;
    case (state)
      ST_RUN: begin
        tmr_clear = 1'b1;
        if (match && !match_q) begin
          state_n = ST_RING;
        end else if (p_stop) begin
          armed_n = ~alarm_armed;
        end else if (p_mode) begin
          load_hr_n  = cur_hr;
          load_min_n = cur_min;
          state_n    = ST_SET_HR;
        end else if (p_alarm) begin
          state_n = ST_AL_HR;
        end
      end
      ST_SET_HR: begin
        tmr_clear = 1'b1;
        if (p_stop)      state_n = ST_RUN;
        else if (p_mode) state_n = ST_SET_MIN;
        else if (p_inc)  load_hr_n = wrap_inc(load_hr, MAX_HR);
      end
      ST_SET_MIN: begin
        tmr_clear = 1'b1;
        if (p_stop) begin
          state_n = ST_RUN;
        end else if (p_mode) begin
          load_n  = 1'b1;
          state_n = ST_RUN;
        end else if (p_inc) begin
          load_min_n = wrap_inc(load_min, MAX_MIN);
        end
      end
      ST_AL_HR: begin
        tmr_clear = 1'b1;
        if (p_stop)       state_n = ST_RUN;
        else if (p_alarm) state_n = ST_AL_MIN;
        else if (p_inc)   alarm_hr_n = wrap_inc(alarm_hr, MAX_HR);
      end
      ST_AL_MIN: begin
        tmr_clear = 1'b1;
        if (p_stop) begin
          state_n = ST_RUN;
        end else if (p_alarm) begin
          armed_n = 1'b1;
          state_n = ST_RUN;
        end else if (p_inc) begin
          alarm_min_n = wrap_inc(alarm_min, MAX_MIN);
        end
      end
      ST_RING: begin
        if (p_stop) begin
          tmr_clear = 1'b1;
          state_n   = ST_RUN;
        end else if (p_snooze) begin
          tmr_load = 1'b1;
          state_n  = ST_SNOOZE;
        end else if (sec_tick) begin
          if (tmr_terminal) begin
            tmr_clear = 1'b1;
            state_n   = ST_RUN;
          end else begin
            tmr_tick = 1'b1;
          end
        end
      end
      ST_SNOOZE: begin
        if (p_stop) begin
          tmr_clear = 1'b1;
          state_n   = ST_RUN;
        end else if (sec_tick) begin
          if (tmr_terminal) begin
            tmr_clear = 1'b1;
            state_n   = ST_RING;
          end else begin
            tmr_tick = 1'b1;
          end
        end
      end
      default: begin
        tmr_clear = 1'b1;
        state_n   = ST_RUN;
      end
    endcase
  end

  // match_q starts high so nothing fires on the first cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt_enable  <= 1'b1;
      load        <= 1'b0;
      load_hr     <= 8'd0;
      load_min    <= 8'd0;
      alarm_hr    <= 8'd0;
      alarm_min   <= 8'd0;
      alarm_armed <= 1'b0;
      ring        <= 1'b0;
      match_q     <= 1'b1;
    end else begin
      state       <= state_n;
      cnt_enable  <= (state_n != ST_SET_HR) && (state_n != ST_SET_MIN);
      load        <= load_n;
      load_hr     <= load_hr_n;
      load_min    <= load_min_n;
      alarm_hr    <= alarm_hr_n;
      alarm_min   <= alarm_min_n;
      alarm_armed <= armed_n;
      ring        <= (state_n == ST_RING);
      match_q     <= match;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: vector table, hand-written multi-cycle sequences,
// then random stimulus scored against a seconds/minutes-level reference model.
module tb_alarm_clock_ctrl;

  localparam int SNOOZE_MIN = 1;
  localparam int RING_SEC   = 3;
  localparam int TMR_W      = 12;

  localparam logic [2:0] S_RUN = 3'd0, S_SET_HR = 3'd1, S_SET_MIN = 3'd2,
                         S_AL_HR = 3'd3, S_AL_MIN = 3'd4, S_RING = 3'd5, S_SNOOZE = 3'd6;
  // Button vector layout: {stop, snooze, mode, alarm, inc}
  localparam logic [4:0] B_NONE = 5'b00000, B_INC = 5'b00001, B_ALARM = 5'b00010,
                         B_MODE = 5'b00100, B_SNOOZE = 5'b01000, B_STOP = 5'b10000;
  localparam logic [38:0] RESET_OUTS = {1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0, btn_alarm = 1'b0, btn_inc = 1'b0, btn_stop = 1'b0, btn_snooze = 1'b0;
  logic [7:0] cur_hr = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
  logic       cnt_enable, load, alarm_armed, ring;
  logic [7:0] load_hr, load_min, alarm_hr, alarm_min;
  logic [2:0] state_o;

  alarm_clock_ctrl #(
    .SNOOZE_MIN (SNOOZE_MIN),
    .RING_SEC   (RING_SEC),
    .TMR_W      (TMR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sec_tick    (sec_tick),
    .btn_mode    (btn_mode),
    .btn_alarm   (btn_alarm),
    .btn_inc     (btn_inc),
    .btn_stop    (btn_stop),
    .btn_snooze  (btn_snooze),
    .cur_hr      (cur_hr),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .cnt_enable  (cnt_enable),
    .load        (load),
    .load_hr     (load_hr),
    .load_min    (load_min),
    .alarm_hr    (alarm_hr),
    .alarm_min   (alarm_min),
    .alarm_armed (alarm_armed),
    .ring        (ring),
    .state_o     (state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  bit sb_on = 1'b0;
  logic [38:0] exp_q[$];

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] dut_outs();
    return {cnt_enable, load, load_hr, load_min, alarm_hr, alarm_min, alarm_armed, ring, state_o};
  endfunction

  task automatic chk_st(input string name, input logic [2:0] st, input logic rng);
    chk({name, " state"}, 39'(state_o), 39'(st));
    chk({name, " ring"}, 39'(ring), 39'(rng));
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 run, 1 set hour, 2 set minute, 3 alarm hour, 4 alarm minute, 5 ringing, 6 snoozing
  int m_st, m_lhr, m_lmin, m_ahr, m_amin, m_elapsed, m_left;
  bit m_arm, m_prev, m_load;

  function automatic void model_reset();
    m_st = 0; m_lhr = 0; m_lmin = 0; m_ahr = 0; m_amin = 0;
    m_elapsed = 0; m_left = 0; m_arm = 0; m_prev = 1; m_load = 0;
  endfunction

  function automatic void model_step(input logic [4:0] b, input logic tick,
                                     input int hr, input int mn);
    bit fire, rise;
    int act;
    fire   = m_arm && (hr == m_ahr) && (mn == m_amin);
    rise   = fire && !m_prev;
    m_prev = fire;
    m_load = 0;
    if (b[4])      act = 1;
    else if (b[3]) act = 2;
    else if (b[2]) act = 3;
    else if (b[1]) act = 4;
    else if (b[0]) act = 5;
    else           act = 0;
    case (m_st)
      0: begin
        if (rise) begin m_st = 5; m_elapsed = 0; end
        else if (act == 1) m_arm = !m_arm;
        else if (act == 3) begin m_lhr = hr; m_lmin = mn; m_st = 1; end
        else if (act == 4) m_st = 3;
      end
      1: begin
        if (act == 1) m_st = 0;
        else if (act == 3) m_st = 2;
        else if (act == 5) m_lhr = (m_lhr + 1) % 24;
      end
      2: begin
        if (act == 1) m_st = 0;
        else if (act == 3) begin m_load = 1; m_st = 0; end
        else if (act == 5) m_lmin = (m_lmin + 1) % 60;
      end
      3: begin
        if (act == 1) m_st = 0;
        else if (act == 4) m_st = 4;
        else if (act == 5) m_ahr = (m_ahr + 1) % 24;
      end
      4: begin
        if (act == 1) m_st = 0;
        else if (act == 4) begin m_arm = 1; m_st = 0; end
        else if (act == 5) m_amin = (m_amin + 1) % 60;
      end
      5: begin
        if (act == 1) m_st = 0;
        else if (act == 2) begin m_st = 6; m_left = SNOOZE_MIN * 60; end
        else if (tick) begin
          m_elapsed++;
          if (m_elapsed >= RING_SEC) m_st = 0;
        end
      end
      6: begin
        if (act == 1) m_st = 0;
        else if (tick) begin
          m_left--;
          if (m_left == 0) begin m_st = 5; m_elapsed = 0; end
        end
      end
      default: m_st = 0;
    endcase
  endfunction

  function automatic logic [38:0] model_outs();
    logic cen;
    cen = !(m_st == 1 || m_st == 2);
    return {cen, m_load, 8'(m_lhr), 8'(m_lmin), 8'(m_ahr), 8'(m_amin), m_arm,
            (m_st == 5), 3'(m_st)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [4:0] b, input logic tick);
    logic [38:0] e;
    @(negedge clk);
    {btn_stop, btn_snooze, btn_mode, btn_alarm, btn_inc} = b;
    sec_tick = tick;
    model_step(b, tick, int'(cur_hr), int'(cur_min));
    exp_q.push_back(model_outs());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (sb_on) chk("model", dut_outs(), e);
    {btn_stop, btn_snooze, btn_mode, btn_alarm, btn_inc} = B_NONE;
    sec_tick = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hr = 8'(h); cur_min = 8'(m); cur_sec = 8'(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Mid-cycle asynchronous reset: outputs must snap to reset values before any edge.
  task automatic async_reset_check(input string name);
    #2 reset = 1'b1;
    #1 chk(name, dut_outs(), RESET_OUTS);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic refire(input string name);
    set_cur(8, 31, 0); step(B_NONE, 1'b0);
    set_cur(8, 30, 0); step(B_NONE, 1'b0);
    chk_st(name, S_RING, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] btn;
    logic [7:0] hr, mn, sc;
    int         rep;
    logic [38:0] exp;
  } vec_t;

  localparam int NV = 31;
  vec_t tv[NV];

  function automatic vec_t mkv(input logic [4:0] btn, input int hr, input int mn, input int sc,
                               input int rep, input logic [2:0] st, input bit cen, input bit ld,
                               input int lhr, input int lmin, input int ahr, input int amin,
                               input bit arm, input bit rng);
    vec_t v;
    v.btn = btn; v.hr = 8'(hr); v.mn = 8'(mn); v.sc = 8'(sc); v.rep = rep;
    v.exp = {cen, ld, 8'(lhr), 8'(lmin), 8'(ahr), 8'(amin), arm, rng, st};
    return v;
  endfunction

  logic [4:0] rb;

  initial begin
    //            btn            hr  mn  sc rep state      cen ld lhr lmin ahr amin arm rng
    tv[0]  = mkv(B_MODE,         10, 15, 0,  1, S_SET_HR,  0, 0, 10, 15,  0,  0,  0, 0);
    tv[1]  = mkv(B_INC,          10, 15, 0, 14, S_SET_HR,  0, 0,  0, 15,  0,  0,  0, 0);
    tv[2]  = mkv(B_MODE,         10, 15, 0,  1, S_SET_MIN, 0, 0,  0, 15,  0,  0,  0, 0);
    tv[3]  = mkv(B_INC,          10, 15, 0, 50, S_SET_MIN, 0, 0,  0,  5,  0,  0,  0, 0);
    tv[4]  = mkv(B_MODE,         10, 15, 0,  1, S_RUN,     1, 1,  0,  5,  0,  0,  0, 0);
    tv[5]  = mkv(B_NONE,         10, 15, 0,  1, S_RUN,     1, 0,  0,  5,  0,  0,  0, 0);
    tv[6]  = mkv(B_ALARM,        10, 15, 0,  1, S_AL_HR,   1, 0,  0,  5,  0,  0,  0, 0);
    tv[7]  = mkv(B_INC,          10, 15, 0,  7, S_AL_HR,   1, 0,  0,  5,  7,  0,  0, 0);
    tv[8]  = mkv(B_ALARM,        10, 15, 0,  1, S_AL_MIN,  1, 0,  0,  5,  7,  0,  0, 0);
    tv[9]  = mkv(B_INC,          10, 15, 0, 30, S_AL_MIN,  1, 0,  0,  5,  7, 30,  0, 0);
    tv[10] = mkv(B_ALARM,        10, 15, 0,  1, S_RUN,     1, 0,  0,  5,  7, 30,  1, 0);
    tv[11] = mkv(B_NONE,          7, 29, 59, 2, S_RUN,     1, 0,  0,  5,  7, 30,  1, 0);
    tv[12] = mkv(B_NONE,          7, 30, 0,  1, S_RING,    1, 0,  0,  5,  7, 30,  1, 1);
    tv[13] = mkv(B_STOP,          7, 30, 1,  1, S_RUN,     1, 0,  0,  5,  7, 30,  1, 0);
    tv[14] = mkv(B_NONE,          7, 30, 2,  5, S_RUN,     1, 0,  0,  5,  7, 30,  1, 0);
    tv[15] = mkv(B_STOP,          8,  0, 0,  1, S_RUN,     1, 0,  0,  5,  7, 30,  0, 0);
    tv[16] = mkv(B_STOP,          8,  0, 0,  1, S_RUN,     1, 0,  0,  5,  7, 30,  1, 0);
    tv[17] = mkv(B_STOP,          8,  0, 0,  1, S_RUN,     1, 0,  0,  5,  7, 30,  0, 0);
    tv[18] = mkv(B_MODE,          8,  0, 0,  1, S_SET_HR,  0, 0,  8,  0,  7, 30,  0, 0);
    tv[19] = mkv(B_MODE,          8,  0, 0,  1, S_SET_MIN, 0, 0,  8,  0,  7, 30,  0, 0);
    tv[20] = mkv(B_INC,           8,  0, 0,  1, S_SET_MIN, 0, 0,  8,  1,  7, 30,  0, 0);
    tv[21] = mkv(B_STOP,          8,  0, 0,  1, S_RUN,     1, 0,  8,  1,  7, 30,  0, 0);
    tv[22] = mkv(B_NONE,          8,  0, 0,  1, S_RUN,     1, 0,  8,  1,  7, 30,  0, 0);
    tv[23] = mkv(B_ALARM,         8,  0, 0,  1, S_AL_HR,   1, 0,  8,  1,  7, 30,  0, 0);
    tv[24] = mkv(B_INC,           8,  0, 0,  1, S_AL_HR,   1, 0,  8,  1,  8, 30,  0, 0);
    tv[25] = mkv(B_STOP,          8,  0, 0,  1, S_RUN,     1, 0,  8,  1,  8, 30,  0, 0);
    tv[26] = mkv(B_MODE,          8,  0, 0,  1, S_SET_HR,  0, 0,  8,  0,  8, 30,  0, 0);
    tv[27] = mkv(B_MODE | B_INC,  8,  0, 0,  1, S_SET_MIN, 0, 0,  8,  0,  8, 30,  0, 0);
    tv[28] = mkv(B_STOP | B_MODE, 8,  0, 0,  1, S_RUN,     1, 0,  8,  0,  8, 30,  0, 0);
    tv[29] = mkv(B_ALARM | B_INC, 8,  0, 0,  1, S_AL_HR,   1, 0,  8,  0,  8, 30,  0, 0);
    tv[30] = mkv(B_STOP,          8,  0, 0,  1, S_RUN,     1, 0,  8,  0,  8, 30,  0, 0);

    // ---------------- reset ----------------
    model_reset();
    @(posedge clk);
    #1 chk("reset values", dut_outs(), RESET_OUTS);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      set_cur(int'(tv[i].hr), int'(tv[i].mn), int'(tv[i].sc));
      for (int r = 0; r < tv[i].rep; r++) begin
        step(tv[i].btn, 1'b0);
        chk($sformatf("vec%0d load", i), 39'(load), 39'(tv[i].exp[37]));
        chk($sformatf("vec%0d cnt_enable", i), 39'(cnt_enable), 39'(tv[i].exp[38]));
      end
      chk($sformatf("vec%0d outputs", i), dut_outs(), tv[i].exp);
    end

    // ---------------- ring timeout ----------------
    set_cur(8, 0, 0);  step(B_STOP, 1'b0);
    chk("arm for timeout", 39'(alarm_armed), 39'(1));
    set_cur(8, 29, 0); step(B_NONE, 1'b0);
    set_cur(8, 30, 0); step(B_NONE, 1'b0);
    chk_st("fire 08:30", S_RING, 1'b1);
    step(B_NONE, 1'b0);
    chk_st("ring no tick", S_RING, 1'b1);
    for (int k = 1; k <= RING_SEC; k++) begin
      step(B_NONE, 1'b1);
      if (k < RING_SEC) chk_st($sformatf("ring tick%0d", k), S_RING, 1'b1);
      else              chk_st("ring timeout", S_RUN, 1'b0);
    end
    repeat (3) step(B_NONE, 1'b0);
    chk_st("no refire same minute", S_RUN, 1'b0);

    // ---------------- snooze ----------------
    refire("refire for snooze");
    step(B_SNOOZE, 1'b0);
    chk_st("snooze entry", S_SNOOZE, 1'b0);
    for (int k = 1; k <= SNOOZE_MIN * 60; k++) begin
      step(B_NONE, 1'b1);
      if (k < SNOOZE_MIN * 60) chk($sformatf("snooze tick%0d ring", k), 39'(ring), 39'(0));
      else                     chk_st("snooze expiry", S_RING, 1'b1);
    end
    step(B_STOP | B_SNOOZE, 1'b0);
    chk_st("stop beats snooze", S_RUN, 1'b0);
    refire("refire for snooze stop");
    step(B_SNOOZE, 1'b0);
    step(B_NONE, 1'b1);
    step(B_NONE, 1'b1);
    chk_st("snooze counting", S_SNOOZE, 1'b0);
    step(B_STOP, 1'b0);
    chk_st("stop in snooze", S_RUN, 1'b0);
    chk("armed kept after stop", 39'(alarm_armed), 39'(1));

    // ---------------- async reset mid-edit and mid-ring ----------------
    step(B_MODE, 1'b0);
    step(B_MODE, 1'b0);
    step(B_INC, 1'b0);
    chk_st("in set minute", S_SET_MIN, 1'b0);
    async_reset_check("reset mid SET_MIN");
    set_cur(0, 1, 0); step(B_STOP, 1'b0);
    set_cur(0, 0, 0); step(B_NONE, 1'b0);
    chk_st("fire 00:00", S_RING, 1'b1);
    step(B_NONE, 1'b1);
    async_reset_check("reset mid RING");
    for (int k = 0; k < 4; k++) begin
      step(B_NONE, 1'b0);
      chk_st($sformatf("post reset idle%0d", k), S_RUN, 1'b0);
    end

    // ---------------- random vs model ----------------
    set_cur(0, 0, 0);
    do_reset();
    sb_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)
        set_cur($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 59));
      rb = B_NONE;
      if ($urandom_range(0, 29) == 0) rb[4] = 1'b1;
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 9) == 0) rb[j] = 1'b1;
      if ($urandom_range(0, 499) == 0) do_reset();
      step(rb, 1'($urandom_range(0, 1)));
    end
    sb_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
